// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, branch-queue entry and the branch-resolve FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  taken;
    word_t target;
  } br_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

  localparam word_t INSN_BYTES = 32'd4;

endpackage

// File: rtl/br_resolve_if.sv
// Fetch/execute/predictor-facing signal bundle of br_resolve; slave is the resolver side.
interface br_resolve_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
);
    cpu_types_pkg::word_t pred_pc, pred_target, res_target, upd_target, redirect_pc;
    logic                 pred_valid, pred_taken, pred_full;
    logic                 res_valid, res_taken;
    logic                 upd_valid, upd_taken, upd_correct;
    logic [IDX_W-1:0]     upd_index;
    logic                 flush, underflow_err;
    logic [CNT_W-1:0]     mispredict_cnt;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_full, upd_valid, upd_index, upd_taken, upd_correct, upd_target,
        input  flush, redirect_pc, mispredict_cnt, underflow_err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_full, upd_valid, upd_index, upd_taken, upd_correct, upd_target,
        output flush, redirect_pc, mispredict_cnt, underflow_err
    );
endinterface

// File: rtl/br_queue.sv
// In-order circular FIFO of in-flight branch predictions with a one-cycle clear.
module br_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  br_entry_t                din,
    output br_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    br_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[head];

    // NOTE: the storage array is deliberately not reset; count gates every read,
    // so stale words are never observed and the array maps to plain RAM.
    always_ff @(posedge CLK) begin
        if (do_push) mem[tail] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/br_resolve.sv
// Compares queued branch predictions with execute outcomes; emits predictor updates,
// a one-cycle flush with redirect PC on mispredicts, and mispredict statistics.
module br_resolve
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
) (
    input logic         CLK,
    input logic         nRST,
    br_resolve_if.slave bus
);
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    br_state_t        state, state_nx;
    br_entry_t        head_e, push_e;
    logic [CW-1:0]    count;
    logic             q_full, q_empty;
    logic             push, pop, clear, mis;

    logic             upd_valid, upd_taken, upd_correct, underflow_err;
    logic [IDX_W-1:0] upd_index;
    word_t            upd_target, redirect_pc;
    logic [CNT_W-1:0] mis_cnt;

    assign push_e = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

    br_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (push_e),
        .dout  (head_e),
        .count (count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Target only matters when both prediction and outcome say taken.
    assign mis = (head_e.taken != bus.res_taken) ||
                 (head_e.taken && bus.res_taken && (head_e.target != bus.res_target));

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        clear    = 1'b0;
        push     = 1'b0;
        unique case (state)
            RUN: begin
                pop = bus.res_valid && !q_empty;
                if (pop && mis) begin
                    clear    = 1'b1;
                    state_nx = FLUSH;
                end
                push = bus.pred_valid && !clear && (!q_full || pop);
            end
            FLUSH:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            upd_valid     <= 1'b0;
            upd_index     <= '0;
            upd_taken     <= 1'b0;
            upd_correct   <= 1'b0;
            upd_target    <= '0;
            redirect_pc   <= '0;
            mis_cnt       <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid <= pop;
            if (pop) begin
                upd_index   <= head_e.pc[IDX_W+1:2];
                upd_taken   <= bus.res_taken;
                upd_correct <= !mis;
                upd_target  <= bus.res_target;
            end
            if (pop && mis) begin
                redirect_pc <= bus.res_taken ? bus.res_target : head_e.pc + INSN_BYTES;
                if (mis_cnt != '1) mis_cnt <= mis_cnt + 1'b1;
            end
            if (state == RUN && bus.res_valid && q_empty) underflow_err <= 1'b1;
        end
    end

    assign bus.pred_full      = (count == FULL_CNT) || (state == FLUSH);
    assign bus.flush          = (state == FLUSH);
    assign bus.redirect_pc    = redirect_pc;
    assign bus.upd_valid      = upd_valid;
    assign bus.upd_index      = upd_index;
    assign bus.upd_taken      = upd_taken;
    assign bus.upd_correct    = upd_correct;
    assign bus.upd_target     = upd_target;
    assign bus.mispredict_cnt = mis_cnt;
    assign bus.underflow_err  = underflow_err;
endmodule
